sort_link_master: RTL and testbench

//  Initiator for the 6-word sort engine port (in_valid/mode/data_in -> out_valid/data_out).

---
 rtl/sort_link_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sort_link_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_link_master.sv
// ---------------------------------------------------------------------------
// sort_link_master
//
// Initiator for a word-serial sort engine. One packed frame is accepted from
// an upstream ready/valid port, streamed into the engine one word per cycle,
// and the engine's returned burst is collected. The returned burst is then
// checked against the sent frame and handed back upstream with error flags.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     in   upstream frame valid
//   req_ready     out  frame can be accepted (high only in IDLE)
//   req_mode      in   0 = pass-through, 1 = sort descending
//   req_data      in   N*DW packed frame, word k = req_data[k*DW +: DW]
//   in_valid      out  engine word strobe
//   mode          out  engine mode, held from SEND start until DONE exit
//   data_in       out  engine word
//   out_valid     in   engine returned-word strobe
//   data_out      in   engine returned word
//   rsp_valid     out  result valid, held until rsp_ready
//   rsp_ready     in   upstream accepts the result
//   rsp_data      out  N*DW returned words, word k = k-th word received
//   rsp_err       out  {timeout, short_burst, check_fail}, 3'b000 = pass
//   dbg_state     out  current FSM state (IDLE=0 SEND=1 WAIT=2 RECV=3 DONE=4)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge;
// ready may be driven independently of valid. On the request port the block
// is the sink (req_ready is high only in IDLE); on the response port it is
// the source (rsp_valid/rsp_data/rsp_err are held until rsp_ready).
// The engine side has no backpressure: in_valid and out_valid are strobes.
//
// Every output is a flop (or a constant-free copy of one), so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module sort_link_master #(
  parameter int DW      = 9,
  parameter int N       = 6,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [N*DW-1:0] req_data,
  output logic            in_valid,
  output logic            mode,
  output logic [DW-1:0]   data_in,
  input  logic            out_valid,
  input  logic [DW-1:0]   data_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N*DW-1:0] rsp_data,
  output logic [2:0]      rsp_err,
  output logic [2:0]      dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Sum width: DW+3 bits holds N*(2^DW-1) without overflow for N <= 8.
  localparam int SW = DW + 3;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;

  // Frame as sent and frame as received.
  logic [DW-1:0]   r_tx [N];
  logic [DW-1:0]   r_rx [N];
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tmo;

  // Registered outputs.
  logic            r_req_ready;
  logic            r_in_valid;
  logic            r_mode;
  logic [DW-1:0]   r_data_in;
  logic            r_rsp_valid;
  logic [N*DW-1:0] r_rsp_data;
  logic [2:0]      r_rsp_err;

  // Receive path: the word captured on this edge is merged into the buffer
  // combinationally so the check sees the complete burst on the same edge
  // that enters DONE.
  logic            w_capture;
  logic [DW-1:0]   w_rx_nxt [N];
  logic [N*DW-1:0] w_rx_packed;
  logic [SW-1:0]   w_sum_tx;
  logic [SW-1:0]   w_sum_rx;
  logic            w_mismatch;
  logic            w_order_bad;
  logic            w_check_fail;
  logic            w_tmo_exp;

  always_comb begin
    w_capture   = out_valid && ((r_state == S_WAIT) || (r_state == S_RECV));
    w_tmo_exp   = (r_tmo == TMO_MAX);
    w_rx_packed = '0;
    w_sum_tx    = '0;
    w_sum_rx    = '0;
    w_mismatch  = 1'b0;
    w_order_bad = 1'b0;

    for (int k = 0; k < N; k++) begin
      w_rx_nxt[k] = r_rx[k];
    end
    if (w_capture) begin
      w_rx_nxt[r_cnt] = data_out;
    end

    for (int k = 0; k < N; k++) begin
      w_rx_packed[k*DW +: DW] = w_rx_nxt[k];
      w_sum_tx = w_sum_tx + SW'(r_tx[k]);
      w_sum_rx = w_sum_rx + SW'(w_rx_nxt[k]);
      if (w_rx_nxt[k] != r_tx[k]) begin
        w_mismatch = 1'b1;
      end
    end

    // Descending result must be non-increasing.
    for (int k = 0; k < N - 1; k++) begin
      if (w_rx_nxt[k] < w_rx_nxt[k+1]) begin
        w_order_bad = 1'b1;
      end
    end

    // Sorting must preserve content; the sum is a cheap conservation check.
    w_check_fail = r_mode ? (w_order_bad || (w_sum_rx != w_sum_tx)) : w_mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_req_ready <= 1'b1;
      r_in_valid  <= 1'b0;
      r_mode      <= 1'b0;
      r_data_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= '0;
      for (int k = 0; k < N; k++) begin
        r_tx[k] <= '0;
        r_rx[k] <= '0;
      end
    end else begin
      if (w_capture) begin
        for (int k = 0; k < N; k++) begin
          r_rx[k] <= w_rx_nxt[k];
        end
      end

      case (r_state)
        S_IDLE: begin
          // r_req_ready is high throughout IDLE.
          if (req_valid) begin
            for (int k = 0; k < N; k++) begin
              r_tx[k] <= req_data[k*DW +: DW];
              r_rx[k] <= '0;   // unreceived words read back as zero
            end
            r_mode      <= req_mode;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_in_valid  <= 1'b1;
            r_data_in   <= req_data[DW-1:0];
            r_state     <= S_SEND;
          end
        end

        S_SEND: begin
          // data_in already shows word r_cnt; advance or finish the burst.
          if (r_cnt == CNT_LAST) begin
            r_in_valid <= 1'b0;
            r_data_in  <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_data_in <= r_tx[r_cnt + CW'(1)];
          end
        end

        S_WAIT: begin
          if (!w_tmo_exp) begin
            r_tmo <= r_tmo + TW'(1);
          end
          if (out_valid) begin
            r_cnt   <= CW'(1);
            r_state <= S_RECV;
          end else if (w_tmo_exp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rx_packed;
            r_rsp_err   <= 3'b100;
            r_state     <= S_DONE;
          end
        end

        S_RECV: begin
          if (!w_tmo_exp) begin
            r_tmo <= r_tmo + TW'(1);
          end
          if (out_valid && (r_cnt == CNT_LAST)) begin
            // Burst complete: the last word wins over a coincident expiry.
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rx_packed;
            r_rsp_err   <= {2'b00, w_check_fail};
            r_state     <= S_DONE;
          end else if (w_tmo_exp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rx_packed;
            r_rsp_err   <= 3'b100;
            r_state     <= S_DONE;
          end else if (!out_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rx_packed;
            r_rsp_err   <= 3'b010;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          // Late engine words are not captured here (w_capture is low).
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= '0;
            r_mode      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_in_valid  <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign in_valid  = r_in_valid;
  assign mode      = r_mode;
  assign data_in   = r_data_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sort_link_master.sv
// ---------------------------------------------------------------------------
// tb_sort_link_master
//
// Directed bench for sort_link_master. The bench plays both the upstream
// requester and the sort engine. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point, so each tick() observes the result
// of exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_sort_link_master;

  localparam int DW      = 9;
  localparam int N       = 6;
  localparam int TIMEOUT = 64;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_mode;
  logic [N*DW-1:0] req_data;
  logic            in_valid;
  logic            mode;
  logic [DW-1:0]   data_in;
  logic            out_valid;
  logic [DW-1:0]   data_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [N*DW-1:0] rsp_data;
  logic [2:0]      rsp_err;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  sort_link_master #(.DW(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .in_valid  (in_valid),
    .mode      (mode),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of the packed frame is argument wk.
  function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                         input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                                         input logic [DW-1:0] w4, input logic [DW-1:0] w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  // ---------------- driver tasks ----------------
  // Offers a frame, checks the SEND burst, leaves the DUT in WAIT.
  task automatic do_request(input logic m, input logic [N*DW-1:0] frame, input bit noise);
    req_valid = 1'b1;
    req_mode  = m;
    req_data  = frame;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL req_ready_idle got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    req_data  = '0;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (in_valid !== 1'b1 || data_in !== frame[k*DW +: DW] || mode !== m) begin
        n_errors++;
        $display("FAIL send_word%0d got v=%b d=%0d m=%b want v=1 d=%0d m=%b",
                 k, in_valid, data_in, mode, frame[k*DW +: DW], m);
      end
      if (noise) begin
        out_valid = 1'b1;
        data_out  = 9'h1AA;
      end
      tick();
    end
    out_valid = 1'b0;
    data_out  = '0;
    n_checks++;
    if (in_valid !== 1'b0 || data_in !== '0 || dbg_state !== 3'd2 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL send_end got v=%b d=%0d st=%0d rdy=%b want v=0 d=0 st=2 rdy=0",
               in_valid, data_in, dbg_state, req_ready);
    end
  endtask

  // Engine model: gap idle cycles, then n words from the packed vector,
  // optionally followed by one surplus word.
  task automatic engine_reply(input int gap, input int n, input logic [N*DW-1:0] words,
                              input bit with_extra, input logic [DW-1:0] extra);
    for (int i = 0; i < gap; i++) tick();
    for (int i = 0; i < n; i++) begin
      out_valid = 1'b1;
      data_out  = words[i*DW +: DW];
      tick();
    end
    if (with_extra) begin
      out_valid = 1'b1;
      data_out  = extra;
      tick();
    end
    out_valid = 1'b0;
    data_out  = '0;
  endtask

  // Waits (bounded) for the response, checks it, accepts it.
  task automatic collect(input string name, input logic m,
                         input logic [N*DW-1:0] exp_data, input logic [2:0] exp_err);
    int waited = 0;
    while (rsp_valid !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_rsp_valid got %b want 1 within 200 cycles", name, rsp_valid);
      return;
    end
    n_checks++;
    if (rsp_data !== exp_data) begin
      n_errors++;
      $display("FAIL %s_rsp_data got %h want %h", name, rsp_data, exp_data);
    end
    n_checks++;
    if (rsp_err !== exp_err) begin
      n_errors++;
      $display("FAIL %s_rsp_err got %b want %b", name, rsp_err, exp_err);
    end
    n_checks++;
    if (mode !== m || req_ready !== 1'b0 || dbg_state !== 3'd4) begin
      n_errors++;
      $display("FAIL %s_done_state got m=%b rdy=%b st=%0d want m=%b rdy=0 st=4",
               name, mode, req_ready, dbg_state, m);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== 3'd0) begin
      n_errors++;
      $display("FAIL %s_release got v=%b rdy=%b st=%0d want v=0 rdy=1 st=0",
               name, rsp_valid, req_ready, dbg_state);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    n_checks++;
    if (req_ready !== 1'b1 || in_valid !== 1'b0 || mode !== 1'b0 || data_in !== '0) begin
      n_errors++;
      $display("FAIL reset_req_side got rdy=%b v=%b m=%b d=%0d want 1 0 0 0",
               req_ready, in_valid, mode, data_in);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 3'b000 || dbg_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_rsp_side got v=%b d=%h e=%b st=%0d want 0 0 000 0",
               rsp_valid, rsp_data, rsp_err, dbg_state);
    end
  endtask

  task automatic test_mode0_echo();
    logic [N*DW-1:0] f;
    f = mk(9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0);
    do_request(1'b0, f, 1'b0);
    engine_reply(2, N, f, 1'b0, '0);
    collect("m0_echo", 1'b0, f, 3'b000);
  endtask

  task automatic test_mode0_mismatch();
    logic [N*DW-1:0] f;
    logic [N*DW-1:0] r;
    f = mk(9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0);
    r = mk(9'd5, 9'd4, 9'd9, 9'd2, 9'd1, 9'd0);
    do_request(1'b0, f, 1'b0);
    engine_reply(0, N, r, 1'b0, '0);
    collect("m0_mismatch", 1'b0, r, 3'b001);
  endtask

  task automatic test_mode1_sorted();
    logic [N*DW-1:0] f;
    logic [N*DW-1:0] r;
    f = mk(9'd3, 9'd511, 9'd0, 9'd7, 9'd7, 9'd100);
    r = mk(9'd511, 9'd100, 9'd7, 9'd7, 9'd3, 9'd0);
    do_request(1'b1, f, 1'b0);
    engine_reply(3, N, r, 1'b0, '0);
    collect("m1_sorted", 1'b1, r, 3'b000);
  endtask

  // Consecutive frames with no idle cycle beyond the one IDLE cycle.
  task automatic test_back_to_back();
    logic [N*DW-1:0] f;
    logic [N*DW-1:0] r_order;
    logic [N*DW-1:0] r_sum;
    f       = mk(9'd3, 9'd511, 9'd0, 9'd7, 9'd7, 9'd100);
    r_order = mk(9'd511, 9'd100, 9'd7, 9'd3, 9'd7, 9'd0);   // 3 < 7: out of order
    r_sum   = mk(9'd511, 9'd100, 9'd7, 9'd7, 9'd3, 9'd1);   // ordered, sum 629 != 628
    do_request(1'b1, f, 1'b0);
    engine_reply(1, N, r_order, 1'b0, '0);
    collect("m1_order", 1'b1, r_order, 3'b001);
    do_request(1'b1, f, 1'b0);
    engine_reply(1, N, r_sum, 1'b0, '0);
    collect("m1_sum", 1'b1, r_sum, 3'b001);
  endtask

  task automatic test_short_burst();
    logic [N*DW-1:0] f;
    f = mk(9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0);
    do_request(1'b0, f, 1'b0);
    engine_reply(2, 4, f, 1'b0, '0);
    collect("short", 1'b0, mk(9'd5, 9'd4, 9'd3, 9'd2, 9'd0, 9'd0), 3'b010);
  endtask

  task automatic test_timeout();
    do_request(1'b1, mk(9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6), 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || dbg_state !== 3'd2) begin
      n_errors++;
      $display("FAIL tmo_early got v=%b st=%0d want v=0 st=2", rsp_valid, dbg_state);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 3'b100 || rsp_data !== '0) begin
      n_errors++;
      $display("FAIL tmo_fire got v=%b e=%b d=%h want v=1 e=100 d=0", rsp_valid, rsp_err, rsp_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 3'b100 || rsp_data !== '0 || mode !== 1'b1) begin
        n_errors++;
        $display("FAIL tmo_hold%0d got v=%b e=%b d=%h m=%b want v=1 e=100 d=0 m=1",
                 i, rsp_valid, rsp_err, rsp_data, mode);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mode !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_release got v=%b rdy=%b m=%b want v=0 rdy=1 m=0", rsp_valid, req_ready, mode);
    end
  endtask

  // Engine noise during SEND and a surplus seventh word must not be stored.
  task automatic test_extra_words();
    logic [N*DW-1:0] f;
    f = mk(9'd10, 9'd20, 9'd30, 9'd40, 9'd50, 9'd60);
    do_request(1'b0, f, 1'b1);
    engine_reply(0, N, f, 1'b1, 9'd77);
    collect("extra", 1'b0, f, 3'b000);
  endtask

  task automatic test_reset_mid_send();
    logic [N*DW-1:0] f;
    f = mk(9'd8, 9'd6, 9'd4, 9'd2, 9'd1, 9'd3);
    req_valid = 1'b1;
    req_mode  = 1'b0;
    req_data  = f;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (in_valid !== 1'b1 || data_in !== 9'd2) begin
      n_errors++;
      $display("FAIL rst_pre got v=%b d=%0d want v=1 d=2", in_valid, data_in);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (in_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_async got v=%b rdy=%b rv=%b st=%0d want 0 1 0 0",
               in_valid, req_ready, rsp_valid, dbg_state);
    end
    #2 rst = 1'b0;
    tick();
    do_request(1'b0, f, 1'b0);
    engine_reply(2, N, f, 1'b0, '0);
    collect("after_rst", 1'b0, f, 3'b000);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_data  = '0;
    out_valid = 1'b0;
    data_out  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_mode0_echo();
    test_mode0_mismatch();
    test_mode1_sorted();
    test_back_to_back();
    test_short_burst();
    test_timeout();
    test_extra_words();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
